// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_AUTO_CONVERT_EN: also start a conversion when bin_in_i changes while idle.
module bcd_dabble_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_out_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MaxBin = (64'(1) << BIN_W) - 1;
  localparam longint unsigned MaxBcd = pow10(DIGITS) - 1;

  // The digit count must cover the full binary range; no runtime overflow path exists.
  if (MaxBin > MaxBcd) begin : g_param_check
    $error("bcd_dabble_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   shifted;
  logic              go;

`ifdef BCD_AUTO_CONVERT_EN
  logic [BIN_W-1:0]  last_bin_q, last_bin_d;
  assign go = start_i || (bin_in_i != last_bin_q);
`else
  assign go = start_i;
`endif

  // Add-3 correction on every digit in parallel, then shift in the next binary MSB.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BcdW-2:0], bin_q[BIN_W-1]};
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
`ifdef BCD_AUTO_CONVERT_EN
    last_bin_d = last_bin_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go) begin
          bin_d     = bin_in_i;
          scratch_d = '0;
          cnt_d     = CntW'(BIN_W - 1);
          state_d   = StShift;
`ifdef BCD_AUTO_CONVERT_EN
          last_bin_d = bin_in_i;
`endif
        end
      end
      StShift: begin
        scratch_d = shifted;
        bin_d     = bin_q << 1;
        if (cnt_q == '0) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

`ifdef BCD_AUTO_CONVERT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_bin_q <= '0;
    else          last_bin_q <= last_bin_d;
  end
`endif

  assign busy_o    = (state_q == StShift);
  assign done_o    = done_q;
  assign valid_o   = valid_q;
  assign bcd_out_o = bcd_q;

endmodule
